// File: rtl/mem_crypt_bridge.sv
// XOR-keystream crypto bridge between the core memory port and main_memory.
// Optional macro PLAIN_WINDOW_EN: upper address half bypasses crypto.
module mem_crypt_bridge #(
  parameter int          ADDRESS_BITS = 12,
  parameter int          MSG_BITS     = 3,
  parameter logic [31:0] KEY_RESET    = 32'hA5C3_0F1E
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [MSG_BITS-1:0]   in_msg,
  input  logic [ADDRESS_BITS:0] in_address,
  input  logic [31:0]           in_data,
  output logic [MSG_BITS-1:0]   out_msg,
  output logic [ADDRESS_BITS:0] out_address,
  output logic [31:0]           out_data,
  output logic [MSG_BITS-1:0]   mem_msg_out,
  output logic [ADDRESS_BITS:0] mem_address_out,
  output logic [31:0]           mem_data_out,
  input  logic [MSG_BITS-1:0]   mem_msg_in,
  input  logic [ADDRESS_BITS:0] mem_address_in,
  input  logic [31:0]           mem_data_in,
  input  logic                  key_load,
  input  logic [31:0]           key_data,
  output logic                  busy
);

  localparam int AW = ADDRESS_BITS + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [MSG_BITS-1:0] WB_REQ   = MSG_BITS'(1);
  localparam logic [MSG_BITS-1:0] R_REQ    = MSG_BITS'(2);
  localparam logic [MSG_BITS-1:0] MEM_SENT = MSG_BITS'(2);

  logic [1:0]          state;
  logic [MSG_BITS-1:0] req_msg;
  logic [AW-1:0]       req_addr;
  logic [31:0]         req_data;
  logic [31:0]         key;
  logic [31:0]         pend_key;
  logic                pend_v;
  logic [31:0]         key_eff;

  function automatic logic [31:0] ks(
    input logic [31:0]   k,
    input logic [AW-1:0] a
  );
    logic [63:0] r;
    r  = {k, k} << a[4:0];
    ks = k ^ r[63:32] ^ {{(32-AW){1'b0}}, a};
`ifdef PLAIN_WINDOW_EN
    if (a[ADDRESS_BITS]) ks = '0;
`else
`endif
  endfunction

  // A load in IDLE takes effect for a request sampled on the same edge
  assign key_eff = key_load ? key_data : key;

  assign busy            = (state != IDLE);
  assign mem_msg_out     = (state == ISSUE) ? req_msg  : '0;
  assign mem_address_out = (state == ISSUE) ? req_addr : '0;
  assign mem_data_out    = (state == ISSUE) ? req_data : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      req_msg     <= '0;
      req_addr    <= '0;
      req_data    <= '0;
      key         <= KEY_RESET;
      pend_key    <= '0;
      pend_v      <= 1'b0;
      out_msg     <= '0;
      out_address <= '0;
      out_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          key    <= key_eff;
          pend_v <= 1'b0;
          if (in_msg != '0) begin
            req_msg  <= in_msg;
            req_addr <= in_address;
            req_data <= (in_msg == WB_REQ)
                      ? in_data ^ ks(key_eff, in_address)
                      : in_data;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (key_load) begin
            pend_key <= key_data;
            pend_v   <= 1'b1;
          end
          if (mem_msg_in != '0) begin
            out_msg     <= mem_msg_in;
            out_address <= mem_address_in;
            out_data    <= (mem_msg_in == MEM_SENT && req_msg == R_REQ)
                         ? mem_data_in ^ ks(key, mem_address_in)
                         : mem_data_in;
            state       <= RESP;
          end
        end
        RESP: begin
          out_msg     <= '0;
          out_address <= '0;
          out_data    <= '0;
          state       <= IDLE;
          if (key_load)    key <= key_data;
          else if (pend_v) key <= pend_key;
          pend_v      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_crypt_bridge.sv
// Directed bench for mem_crypt_bridge.
// Expected values are hand-computed keystream results.
module tb_mem_crypt_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  in_msg;
  logic [12:0] in_address;
  logic [31:0] in_data;
  logic [2:0]  out_msg;
  logic [12:0] out_address;
  logic [31:0] out_data;
  logic [2:0]  mem_msg_out;
  logic [12:0] mem_address_out;
  logic [31:0] mem_data_out;
  logic [2:0]  mem_msg_in;
  logic [12:0] mem_address_in;
  logic [31:0] mem_data_in;
  logic        key_load;
  logic [31:0] key_data;
  logic        busy;

  int vecs = 0;
  int errs = 0;

  mem_crypt_bridge dut (
    .clock           (clock),
    .reset           (reset),
    .in_msg          (in_msg),
    .in_address      (in_address),
    .in_data         (in_data),
    .out_msg         (out_msg),
    .out_address     (out_address),
    .out_data        (out_data),
    .mem_msg_out     (mem_msg_out),
    .mem_address_out (mem_address_out),
    .mem_data_out    (mem_data_out),
    .mem_msg_in      (mem_msg_in),
    .mem_address_in  (mem_address_in),
    .mem_data_in     (mem_data_in),
    .key_load        (key_load),
    .key_data        (key_data),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic [2:0]  m,
                     input logic [12:0] a,
                     input logic [31:0] d);
    in_msg     = m;
    in_address = a;
    in_data    = d;
    tick();
  endtask

  task automatic reply(input logic [2:0]  m,
                       input logic [12:0] a,
                       input logic [31:0] d);
    mem_msg_in     = m;
    mem_address_in = a;
    mem_data_in    = d;
    tick();
    mem_msg_in = '0;
    in_msg     = '0;
  endtask

  initial begin
    logic [31:0] win_exp;
`ifdef PLAIN_WINDOW_EN
    win_exp = 32'h0000_0013;
`else
    win_exp = 32'hF9F3_EEE3;
`endif
    reset = 1'b0;
    in_msg = '0; in_address = '0; in_data = '0;
    mem_msg_in = '0; mem_address_in = '0; mem_data_in = '0;
    key_load = 1'b0; key_data = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_msg", 32'(out_msg), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mem_msg", 32'(mem_msg_out), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    tick();

    req(3'd2, 13'h004, 0);
    chk("rd_mem_msg", 32'(mem_msg_out), 2);
    chk("rd_mem_addr", 32'(mem_address_out), 32'h004);
    chk("rd_busy", 32'(busy), 1);
    chk("rd_issue_out", 32'(out_msg), 0);
    tick();
    chk("rd_hold", 32'(mem_msg_out), 2);
    reply(3'd2, 13'h004, 32'hF9F3_FEE3);
    chk("rd_out_msg", 32'(out_msg), 2);
    chk("rd_out_data", out_data, 32'h0000_0013);
    chk("rd_out_addr", 32'(out_address), 32'h004);
    chk("rd_resp_mem", 32'(mem_msg_out), 0);
    tick();
    chk("rd_idle_msg", 32'(out_msg), 0);
    chk("rd_idle_data", out_data, 0);
    chk("rd_idle_busy", 32'(busy), 0);

    req(3'd1, 13'h010, 32'h1234_5678);
    chk("wb_mem_msg", 32'(mem_msg_out), 1);
    chk("wb_mem_data", mem_data_out, 32'hB8E9_FCB5);
    reply(3'd1, 13'h010, 0);
    chk("wb_out_msg", 32'(out_msg), 1);
    tick();
    chk("wb_idle_msg", 32'(out_msg), 0);

    key_load = 1'b1; key_data = 32'h0;
    req(3'd2, 13'h000, 0);
    key_load = 1'b0;
    reply(3'd2, 13'h000, 32'hDEAD_BEEF);
    chk("k0_out_data", out_data, 32'hDEAD_BEEF);
    tick();

    key_load = 1'b1; key_data = 32'hA5C3_0F1E;
    tick();
    key_load = 1'b0;
    req(3'd2, 13'h004, 0);
    key_load = 1'b1; key_data = 32'hFFFF_FFFF;
    tick();
    chk("pend_busy1", 32'(busy), 1);
    key_data = 32'h0;
    tick();
    key_load = 1'b0;
    chk("pend_busy2", 32'(busy), 1);
    reply(3'd2, 13'h004, 32'hF9F3_FEE3);
    chk("pend_old_key", out_data, 32'h0000_0013);
    chk("pend_busy3", 32'(busy), 1);
    tick();
    req(3'd2, 13'h004, 0);
    reply(3'd2, 13'h004, 32'h0000_0055);
    chk("pend_new_key", out_data, 32'h0000_0051);
    tick();

    req(3'd2, 13'h004, 0);
    in_msg = '0;
    reset  = 1'b0;
    #1;
    chk("arst_mem_msg", 32'(mem_msg_out), 0);
    chk("arst_busy", 32'(busy), 0);
    tick();
    reset = 1'b1;
    tick();
    req(3'd2, 13'h004, 0);
    reply(3'd2, 13'h004, 32'hF9F3_FEE3);
    chk("arst_key", out_data, 32'h0000_0013);
    tick();

    req(3'd2, 13'h1004, 0);
    reply(3'd2, 13'h1004, 32'h0000_0013);
    chk("win_out_data", out_data, win_exp);
    tick();

    req(3'd3, 13'h020, 32'hCAFE_BABE);
    chk("pt_mem_msg", 32'(mem_msg_out), 3);
    chk("pt_mem_data", mem_data_out, 32'hCAFE_BABE);
    reply(3'd3, 13'h020, 32'h0000_1234);
    chk("pt_out_msg", 32'(out_msg), 3);
    chk("pt_out_data", out_data, 32'h0000_1234);
    tick();
    chk("pt_idle_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
